pulse_gather: RTL and testbench

Single-clock, multi-channel pulse collector. It counts single-cycle event pulses on up to WIDTH independent channels and reports them one channel at a time over a valid/ready port, so that no pulse is lost while the consumer is busy. Typical consumers are a slow register-update path or a pulse-crossing stage. It sits in front of any consumer that cannot accept a pulse every cycle, and replaces per-channel pulse forwarding wherever pulses may arrive back-to-back.

---
 rtl/pulse_gather_if.sv | 13 +
 rtl/pulse_gather.sv | 110 +++++++++++
 tb/tb_pulse_gather.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gather_if.sv
// Output port of pulse_gather: one transaction (channel, count) under valid/ready.
interface pulse_gather_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [CNT_W-1:0] out_cnt;

  modport master (output out_valid, output out_ch, output out_cnt, input out_ready);
  modport slave  (input out_valid, input out_ch, input out_cnt, output out_ready);
endinterface

// File: rtl/pulse_gather.sv
// Per-channel pulse counters drained round-robin into one registered valid/ready slot; pulse->valid in 2 cycles,
// stalled slot holds steady and counters keep absorbing. PULSE_GATHER_OVF_EN adds sticky ovf/ovf_clr ports.
module pulse_gather #(
  parameter int WIDTH     = 4,
  parameter int CH_W      = 2,
  parameter int CNT_W     = 8,
  parameter int DRAIN_ALL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pulse_in,
  pulse_gather_if.master   dst,
  output logic             busy
`ifdef PULSE_GATHER_OVF_EN
  ,
  output logic [WIDTH-1:0] ovf,
  input  logic [WIDTH-1:0] ovf_clr
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pending     [WIDTH];
  logic [CNT_W-1:0] pending_nxt [WIDTH];
  logic [WIDTH-1:0] nz;
  logic [WIDTH-1:0] sat_hit;
  logic [CH_W-1:0]  last;
  logic [CH_W-1:0]  gnt;
  logic [CH_W-1:0]  gnt_hi;
  logic [CH_W-1:0]  gnt_lo;
  logic             hi_vld;
  logic             lo_vld;
  logic             slot_free;
  logic             load;
  logic [CNT_W-1:0] base;

  // Round-robin: lowest non-zero channel above the last grant, else lowest non-zero overall.
  always_comb begin
    nz     = '0;
    gnt_hi = '0;
    gnt_lo = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      nz[i] = (pending[i] != '0);
      if (nz[i]) begin
        gnt_lo = CH_W'(i);
        lo_vld = 1'b1;
        if (CH_W'(i) > last) begin
          gnt_hi = CH_W'(i);
          hi_vld = 1'b1;
        end
      end
    end
    gnt = hi_vld ? gnt_hi : gnt_lo;
  end

  assign slot_free = !dst.out_valid || dst.out_ready;
  assign load      = slot_free && lo_vld;
  assign busy      = dst.out_valid || (|nz);

  // The drained amount is the pre-edge count; a same-cycle pulse lands on top of the remainder.
  always_comb begin
    base    = '0;
    sat_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      base = pending[i];
      if (load && gnt == CH_W'(i)) begin
        base = (DRAIN_ALL != 0) ? '0 : pending[i] - CNT_W'(1);
      end
      sat_hit[i]     = pulse_in[i] && (base == CNT_MAX);
      pending_nxt[i] = (pulse_in[i] && !sat_hit[i]) ? base + CNT_W'(1) : base;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        pending[i] <= '0;
      end
      last          <= CH_W'(WIDTH - 1);
      dst.out_valid <= 1'b0;
      dst.out_ch    <= '0;
      dst.out_cnt   <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        pending[i] <= pending_nxt[i];
      end
      if (load) begin
        dst.out_valid <= 1'b1;
        dst.out_ch    <= gnt;
        dst.out_cnt   <= (DRAIN_ALL != 0) ? pending[gnt] : CNT_W'(1);
        last          <= gnt;
      end else if (slot_free) begin
        dst.out_valid <= 1'b0;
      end
    end
  end

`ifdef PULSE_GATHER_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~ovf_clr) | sat_hit;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_gather.sv
// Two pulse_gather instances (drain-all and one-per-pulse, CNT_W=4) against an event-level model.
module tb_pulse_gather;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pulse = '0;
  logic       ready = 1'b0;
  logic [3:0] ovf_clr = '0;
  logic       busy_a, busy_b;
  logic [3:0] ovf_a, ovf_b;

  int n_checks = 0;
  int n_err = 0;

  pulse_gather_if #(.CH_W(2), .CNT_W(4)) if_a ();
  pulse_gather_if #(.CH_W(2), .CNT_W(4)) if_b ();
  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

`ifndef PULSE_GATHER_OVF_EN
  assign ovf_a = '0;
  assign ovf_b = '0;
`endif

  pulse_gather #(.WIDTH(4), .CH_W(2), .CNT_W(4), .DRAIN_ALL(1)) u_all (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse), .dst(if_a), .busy(busy_a)
`ifdef PULSE_GATHER_OVF_EN
    , .ovf(ovf_a), .ovf_clr(ovf_clr)
`endif
  );

  pulse_gather #(.WIDTH(4), .CH_W(2), .CNT_W(4), .DRAIN_ALL(0)) u_one (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse), .dst(if_b), .busy(busy_b)
`ifdef PULSE_GATHER_OVF_EN
    , .ovf(ovf_b), .ovf_clr(ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  // Model state: index 0 = drain-all instance, 1 = one-per-pulse instance.
  int m_pend [2][4];
  int m_ptr  [2];
  bit m_vld  [2];
  int m_ch   [2];
  int m_cnt  [2];
  bit m_ovf  [2][4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int  np [4];
    bit  free;
    int  g;
    int  c;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int j = 0; j < 4; j++) begin
          m_pend[k][j] = 0;
          m_ovf[k][j]  = 0;
        end
        m_ptr[k] = 3;
        m_vld[k] = 0;
        m_ch[k]  = 0;
        m_cnt[k] = 0;
      end else begin
        free = !m_vld[k] || ready;
        g = -1;
        if (free) begin
          for (int off = 1; off <= 4; off++) begin
            c = (m_ptr[k] + off) % 4;
            if (g < 0 && m_pend[k][c] > 0) g = c;
          end
        end
        for (int j = 0; j < 4; j++) np[j] = m_pend[k][j];
        if (g >= 0) begin
          m_ch[k]  = g;
          m_cnt[k] = (k == 0) ? m_pend[k][g] : 1;
          np[g]    = (k == 0) ? 0 : m_pend[k][g] - 1;
          m_ptr[k] = g;
          m_vld[k] = 1;
        end else if (free) begin
          m_vld[k] = 0;
        end
        for (int j = 0; j < 4; j++) begin
          if (ovf_clr[j]) m_ovf[k][j] = 0;
          if (pulse[j]) begin
            if (np[j] == 15) m_ovf[k][j] = 1;
            else np[j] = np[j] + 1;
          end
          m_pend[k][j] = np[j];
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input logic v, input logic [1:0] ch,
                            input logic [3:0] cnt, input logic b, input logic [3:0] ov);
    string nm;
    bit    exp_busy;
    nm = (k == 0) ? "all" : "one";
    exp_busy = m_vld[k];
    for (int j = 0; j < 4; j++) if (m_pend[k][j] > 0) exp_busy = 1;
    check({nm, ".valid"}, v, m_vld[k]);
    check({nm, ".ch"}, ch, m_ch[k]);
    check({nm, ".cnt"}, cnt, m_cnt[k]);
    check({nm, ".busy"}, b, exp_busy);
`ifdef PULSE_GATHER_OVF_EN
    for (int j = 0; j < 4; j++) check($sformatf("%s.ovf%0d", nm, j), ov[j], m_ovf[k][j]);
`else
    if (ov != 4'b0) check({nm, ".ovf_absent"}, ov, 0);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_inst(0, if_a.out_valid, if_a.out_ch, if_a.out_cnt, busy_a, ovf_a);
    check_inst(1, if_b.out_valid, if_b.out_ch, if_b.out_cnt, busy_b, ovf_b);
  endtask

  task automatic cyc(input logic [3:0] p, input logic r, input int n);
    repeat (n) begin
      pulse = p;
      ready = r;
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(4'b0000, 1'b0, 1);
    rst_n = 1'b1;
  endtask

  int thr;

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", if_a.out_valid, 0);
    check("rst_busy", busy_a, 0);
    check("rst_cnt", if_a.out_cnt, 0);

    // Isolated pulse on ch2
    cyc(4'b0100, 1'b1, 1);
    check("iso_t1_valid", if_a.out_valid, 0);
    cyc(4'b0000, 1'b1, 1);
    check("iso_t2_valid", if_a.out_valid, 1);
    check("iso_t2_ch", if_a.out_ch, 2);
    check("iso_t2_cnt", if_a.out_cnt, 1);
    cyc(4'b0000, 1'b1, 1);
    check("iso_t3_valid", if_a.out_valid, 0);
    check("iso_t3_busy", busy_a, 0);

    // Burst behind a stalled slot holding ch0
    do_reset();
    cyc(4'b0001, 1'b0, 1);
    cyc(4'b0000, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc((i < 2) ? 4'b1010 : 4'b0010, 1'b0, 1);
      check("stall_ch", if_a.out_ch, 0);
      check("stall_cnt", if_a.out_cnt, 1);
    end
    cyc(4'b0000, 1'b1, 1);
    check("burst1_ch", if_a.out_ch, 1);
    check("burst1_cnt", if_a.out_cnt, 5);
    cyc(4'b0000, 1'b1, 1);
    check("burst2_valid", if_a.out_valid, 1);
    check("burst2_ch", if_a.out_ch, 3);
    check("burst2_cnt", if_a.out_cnt, 2);
    cyc(4'b0000, 1'b1, 1);
    check("burst_end_valid", if_a.out_valid, 0);

    // Round-robin, one transaction per pulse
    do_reset();
    cyc(4'b1111, 1'b0, 3);
    check("rr0_ch", if_b.out_ch, 0);
    for (int i = 1; i < 12; i++) begin
      cyc(4'b0000, 1'b1, 1);
      check("rr_valid", if_b.out_valid, 1);
      check("rr_ch", if_b.out_ch, i % 4);
      check("rr_cnt", if_b.out_cnt, 1);
    end
    cyc(4'b0000, 1'b1, 1);
    check("rr_end_valid", if_b.out_valid, 0);

    // Pulse on the same edge that drains the channel
    do_reset();
    cyc(4'b0010, 1'b0, 1);
    cyc(4'b0000, 1'b0, 1);
    cyc(4'b0001, 1'b0, 3);
    cyc(4'b0001, 1'b1, 1);
    check("same_ch", if_a.out_ch, 0);
    check("same_cnt", if_a.out_cnt, 3);
    cyc(4'b0000, 1'b1, 1);
    check("same_next_ch", if_a.out_ch, 0);
    check("same_next_cnt", if_a.out_cnt, 1);
    check("same_next_valid", if_a.out_valid, 1);
    cyc(4'b0000, 1'b1, 1);
    check("same_end_valid", if_a.out_valid, 0);

    // Saturation at 15
    do_reset();
    cyc(4'b0001, 1'b0, 1);
    cyc(4'b0000, 1'b0, 1);
    cyc(4'b0100, 1'b0, 20);
    cyc(4'b0000, 1'b1, 1);
    check("sat_ch", if_a.out_ch, 2);
    check("sat_cnt", if_a.out_cnt, 15);
`ifdef PULSE_GATHER_OVF_EN
    check("sat_ovf_set", ovf_a[2], 1);
    ovf_clr = 4'b0100;
    cyc(4'b0000, 1'b1, 1);
    ovf_clr = 4'b0000;
    check("sat_ovf_clr", ovf_a[2], 0);
`endif

    // Reset while a transaction is presented and counts are pending
    do_reset();
    cyc(4'b0011, 1'b0, 2);
    check("pre_rst_valid", if_a.out_valid, 1);
    rst_n = 1'b0;
    cyc(4'b0001, 1'b0, 1);
    rst_n = 1'b1;
    check("midrst_valid", if_a.out_valid, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_busy_one", busy_b, 0);
    cyc(4'b1000, 1'b1, 1);
    cyc(4'b0111, 1'b1, 1);
    check("midrst_first_ch", if_a.out_ch, 3);
    check("midrst_first_valid", if_a.out_valid, 1);
    cyc(4'b0000, 1'b1, 1);
    check("midrst_second_ch", if_a.out_ch, 0);

    // Randomized traffic with varying backpressure
    thr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) thr = $urandom_range(0, 2) * 45 + 5;
      pulse   = 4'($urandom & $urandom);
      ready   = ($urandom_range(0, 99) < thr);
      ovf_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      rst_n   = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    ovf_clr = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
